seq_mult: RTL
=============

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: multiplicand.
REQ-006 The block SHALL have port b, input, WIDTH bits: multiplier.
REQ-007 The block SHALL have port prod, output, 2*WIDTH bits: registered full-width product.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a multiply is in progress or being reported.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking prod valid for a new result.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN and DONE; busy SHALL be high exactly when the state is not IDLE.
REQ-011 In IDLE, a rising edge with start=1 SHALL latch a and b, clear the accumulator, load the iteration counter with WIDTH, and enter RUN.
REQ-012 Zero early-out: if either latched operand is 0, the start edge SHALL instead set prod to 0 and enter DONE directly, with done high the following cycle.
REQ-013 Each RUN edge SHALL perform one radix-2 shift-add step: if the multiplier LSB is 1, add the multiplicand into the upper WIDTH+1 bits of the accumulator; shift the accumulator and multiplier right by 1; decrement the counter.
REQ-014 When the counter reaches 0, the same edge SHALL load prod with the 2*WIDTH-bit result and enter DONE.
REQ-015 The result SHALL be ready WIDTH+1 cycles after the start edge: done high during the cycle after edge WIDTH.
REQ-016 DONE SHALL last exactly one cycle (done=1), then return to IDLE.
REQ-017 prod SHALL hold its value from DONE until the next result is loaded.
REQ-018 start SHALL be ignored in RUN and DONE, with no effect on the operation in progress; the minimum start-to-start interval is WIDTH+2 cycles.
REQ-019 a and b SHALL be don't-care except on the accepting start edge.
REQ-020 Accumulator addition SHALL keep the carry (WIDTH+1-bit sum); no product bit SHALL ever be lost.

Reset
REQ-021 Asserting rst_n low SHALL immediately force state=IDLE, prod=0, busy=0, done=0, and clear the counter and all internal registers, including mid-operation.
REQ-022 A start held high while rst_n rises SHALL be accepted on the first clk edge with rst_n high.

Configuration
REQ-023 With macro SEQ_MULT_SIGNED_EN defined, a and b SHALL be two's-complement:
- on acceptance, latch magnitudes and sign = a[WIDTH-1]^b[WIDTH-1]
- on completion, prod = sign ? -magnitude : magnitude, in 2*WIDTH-bit two's complement
- most-negative operands SHALL be handled exactly, e.g. WIDTH=16: 0x8000*0x8000 = 0x40000000
- latency SHALL be unchanged.
REQ-024 Without SEQ_MULT_SIGNED_EN, operands and product SHALL be unsigned, and no sign logic SHALL be present.

Verification (WIDTH=16)
REQ-025 Basic multiply: a=3, b=5, start pulse at edge 0 -> busy=1, done=1 only in the cycle after edge 16, prod=0x0000000F.
REQ-026 Maximum operands: a=0xFFFF, b=0xFFFF -> prod=0xFFFE0001 after 17 cycles, with no carry loss.
REQ-027 Zero early-out: a=0, b=0x1234 -> done=1 in the cycle after the start edge, prod=0; busy falls one cycle later.
REQ-028 Start while busy: a=7, b=9, then start with a=2, b=2 at edge 5 -> prod=0x0000003F, and no second done appears.
REQ-029 Reset mid-operation: rst_n low at cycle 8 of a run -> prod=0, busy=0, done=0 asynchronously; a new start after release gives a correct result.
REQ-030 Signed mode (SEQ_MULT_SIGNED_EN defined): a=0xFFFD (-3), b=5 -> prod=0xFFFFFFF1; a=0x8000, b=0x8000 -> prod=0x40000000.

Source files
------------

// File: rtl/seq_mult.sv
// Sequential radix-2 shift-add multiplier: WIDTH+1 cycles per product, zero early-out.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands and product.
module seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] result;

`ifdef SEQ_MULT_SIGNED_EN
    logic sign;

    // Negating the most-negative value yields itself, which read unsigned is the exact magnitude.
    assign a_mag  = a[WIDTH-1] ? -a : a;
    assign b_mag  = b[WIDTH-1] ? -b : b;
    assign result = sign ? -acc_next : acc_next;
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign result = acc_next;
`endif

    // The carry out of the upper-half add becomes the new accumulator MSB.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_next = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            prod   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= CW'(WIDTH);
`ifdef SEQ_MULT_SIGNED_EN
                        sign   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
                        if (a == '0 || b == '0) begin
                            prod  <= '0;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        prod  <= result;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
